// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-only data memory: word accesses pass through,
// sub-word stores use read-modify-write, sub-word loads are extracted and extended.
// Optional address bounds fault: define LSU_BOUNDS_CHECK_EN.
module dmem_lsu #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
`ifdef LSU_BOUNDS_CHECK_EN
    output logic        resp_fault,
`endif
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
`endif

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    // Holds the extended load result, or the old word during a read-modify-write.
    logic [31:0] data_q, data_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;
    logic        req_bad_align;
    logic        req_out_of_range;

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_BU:   res = {24'h0, b};
            F3_HU:   res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] res;
        res = old_word;
        if (f3[0]) begin
            if (lane[1]) res[31:16] = wd[15:0];
            else         res[15:0]  = wd[15:0];
        end else begin
            case (lane)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                default: res[31:24] = wd[7:0];
            endcase
        end
        return res;
    endfunction

    // Illegal widths are folded into the misaligned response.
    always_comb begin
        case (req_funct3)
            F3_B, F3_BU: req_bad_align = 1'b0;
            F3_H, F3_HU: req_bad_align = req_addr[0];
            F3_W:        req_bad_align = (req_addr[1:0] != 2'b00);
            default:     req_bad_align = 1'b1;
        endcase
    end

`ifdef LSU_BOUNDS_CHECK_EN
    assign req_out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_W);
`else
    assign req_out_of_range = 1'b0;
`endif

    // NOTE: every output and next-state value gets a default before the case
    // statement, so no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        funct3_d        = funct3_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        data_d          = data_q;
        mis_d           = mis_q;
        fault_d         = fault_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'h0;
        resp_misaligned = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
        resp_fault      = 1'b0;
`endif
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        addr            = 32'h0;
        write_data      = 32'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    data_d   = 32'h0;
                    mis_d    = req_bad_align;
                    fault_d  = !req_bad_align && req_out_of_range;
                    if (req_bad_align || req_out_of_range) begin
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                MemRead = 1'b1;
                addr    = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    data_d  = read_data;
                    state_d = S_WR;
                end else begin
                    data_d  = load_extract(funct3_q, addr_q[1:0], read_data);
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                MemWrite   = 1'b1;
                addr       = {addr_q[31:2], 2'b00};
                write_data = (funct3_q == F3_W) ? wdata_q
                           : store_merge(funct3_q, addr_q[1:0], data_q, wdata_q);
                data_d     = 32'h0;
                state_d    = S_RESP;
            end
            default: begin
                resp_valid      = 1'b1;
                resp_rdata      = data_q;
                resp_misaligned = mis_q;
`ifdef LSU_BOUNDS_CHECK_EN
                resp_fault      = fault_q;
`endif
                state_d         = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            data_q   <= 32'h0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a word-wide behavioural dmem.
// Honours LSU_BOUNDS_CHECK_EN for the out-of-range access step.
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
`ifdef LSU_BOUNDS_CHECK_EN
    logic        resp_fault;
`endif
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    dmem_lsu #(.MEM_DEPTH(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
`ifdef LSU_BOUNDS_CHECK_EN
        .resp_fault      (resp_fault),
`endif
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .addr            (addr),
        .write_data      (write_data),
        .read_data       (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory larger than MEM_DEPTH so an unchecked out-of-range access is observable.
    logic [31:0] mem [0:511];
    logic        pre_we;
    logic [8:0]  pre_idx;
    logic [31:0] pre_data;

    assign read_data = MemRead ? mem[addr[10:2]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite)    mem[addr[10:2]] <= write_data;
        else if (pre_we) mem[pre_idx]    <= pre_data;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_mis;
    logic        r_fault;
    logic        r_after;
    logic        saw_rd, saw_wr, saw_both;
    int          n_wr;
    logic [31:0] wr_addr, wr_data;

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = a[10:2]; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        // Scramble the request bus: the LSU must work from its registered copy.
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        r_lat = 99; r_rdata = 32'hX; r_mis = 1'bX; r_fault = 1'bX; r_after = 1'bX;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_both = 1'b0; n_wr = 0;
        wr_addr = 32'h0; wr_data = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (MemRead) saw_rd = 1'b1;
            if (MemWrite) begin
                saw_wr = 1'b1; n_wr++; wr_addr = addr; wr_data = write_data;
            end
            if (MemRead && MemWrite) saw_both = 1'b1;
            if (resp_valid) begin
                r_lat = c; r_rdata = resp_rdata; r_mis = resp_misaligned;
`ifdef LSU_BOUNDS_CHECK_EN
                r_fault = resp_fault;
`else
                r_fault = 1'b0;
`endif
                break;
            end
        end
        @(negedge clk);
        r_after = resp_valid;
    endtask

    logic saw_resp;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 9'h0; pre_data = 32'h0;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_mis", 32'(resp_misaligned), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // SW then LW of a full word
        run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_latency", 32'(r_lat), 32'd2);
        check("sw_write_count", 32'(n_wr), 32'd1);
        check("sw_addr", wr_addr, 32'h10);
        check("sw_wdata", wr_data, 32'hDEAD_BEEF);
        check("sw_no_read", 32'(saw_rd), 32'd0);
        check("sw_rdata", r_rdata, 32'h0);
        check("sw_pulse_one_cycle", 32'(r_after), 32'd0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_latency", 32'(r_lat), 32'd2);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_mis", 32'(r_mis), 32'd0);
        check("lw_no_write", 32'(saw_wr), 32'd0);

        // SB read-modify-write into lane 1
        preload(32'h20, 32'h1234_5678);
        run_req(1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB);
        check("sb_latency", 32'(r_lat), 32'd3);
        check("sb_did_read", 32'(saw_rd), 32'd1);
        check("sb_wdata", wr_data, 32'h1234_AB78);
        check("sb_addr", wr_addr, 32'h20);
        check("sb_mem", mem[8], 32'h1234_AB78);
        run_req(1'b0, 3'b100, 32'h21, 32'h0);
        check("lbu_21", r_rdata, 32'h0000_00AB);
        run_req(1'b0, 3'b000, 32'h21, 32'h0);
        check("lb_21", r_rdata, 32'hFFFF_FFAB);

        // Halfword loads
        preload(32'h30, 32'h8001_7FFF);
        run_req(1'b0, 3'b001, 32'h32, 32'h0);
        check("lh_32", r_rdata, 32'hFFFF_8001);
        run_req(1'b0, 3'b101, 32'h32, 32'h0);
        check("lhu_32", r_rdata, 32'h0000_8001);
        run_req(1'b0, 3'b001, 32'h30, 32'h0);
        check("lh_30", r_rdata, 32'h0000_7FFF);
        run_req(1'b0, 3'b000, 32'h33, 32'h0);
        check("lb_33", r_rdata, 32'hFFFF_FF80);

        // Misaligned and illegal widths
        run_req(1'b0, 3'b010, 32'h13, 32'h0);
        check("lw13_latency", 32'(r_lat), 32'd1);
        check("lw13_mis", 32'(r_mis), 32'd1);
        check("lw13_rdata", r_rdata, 32'h0);
        check("lw13_no_access", 32'({saw_rd, saw_wr}), 32'd0);
        run_req(1'b1, 3'b001, 32'h21, 32'h0000_BEEF);
        check("sh21_latency", 32'(r_lat), 32'd1);
        check("sh21_mis", 32'(r_mis), 32'd1);
        check("sh21_no_access", 32'({saw_rd, saw_wr}), 32'd0);
        check("sh21_mem_kept", mem[8], 32'h1234_AB78);
        run_req(1'b0, 3'b011, 32'h10, 32'h0);
        check("f3_011_mis", 32'(r_mis), 32'd1);
        check("f3_011_no_access", 32'({saw_rd, saw_wr}), 32'd0);

        // SH into upper half
        run_req(1'b1, 3'b001, 32'h22, 32'h1234_BEEF);
        check("sh22_latency", 32'(r_lat), 32'd3);
        check("sh22_mem", mem[8], 32'hBEEF_AB78);
        check("never_both", 32'(saw_both), 32'd0);

        // Reset while in WR of a SW
        preload(32'h40, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wr", 32'(MemWrite), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_memwrite_drop", 32'(MemWrite), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        saw_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("abort_no_resp", 32'(saw_resp), 32'd0);
        check("abort_mem_kept", mem[16], 32'h0);

        // Access beyond MEM_DEPTH
        preload(32'h400, 32'hCAFE_F00D);
        run_req(1'b0, 3'b010, 32'h400, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
        check("oob_latency", 32'(r_lat), 32'd1);
        check("oob_fault", 32'(r_fault), 32'd1);
        check("oob_no_read", 32'(saw_rd), 32'd0);
        check("oob_rdata", r_rdata, 32'h0);
        run_req(1'b0, 3'b010, 32'h402, 32'h0);
        check("oob_mis_priority", 32'({r_mis, r_fault}), 32'b10);
`else
        check("oob_latency", 32'(r_lat), 32'd2);
        check("oob_read", 32'(saw_rd), 32'd1);
        check("oob_rdata", r_rdata, 32'hCAFE_F00D);
        check("oob_no_fault", 32'(r_fault), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
